req_encoder: RTL and testbench

//  Inverse of the 4-to-16 register-select decoder: collects one-hot/multi-hot request lines

---
 rtl/req_encoder.sv | 79 +++++++
 tb/tb_req_encoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/req_encoder.sv
// Request encoder: collects 16 sticky request lines and presents one slot address at a time
// on a valid/ack handshake, with round-robin or fixed lowest-index-first arbitration.
module req_encoder #(
  parameter int NUM_REQ     = 16,
  parameter int ADDR_W      = 4,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [ADDR_W-1:0]  addr,
  output logic               valid,
  input  logic               ack,
  output logic               busy,
  output logic               overrun
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0]         state;
  logic [NUM_REQ-1:0] pending;
  logic [ADDR_W-1:0]  ptr;

  logic [NUM_REQ-1:0] new_req;
  logic [NUM_REQ-1:0] clear_mask;
  logic [ADDR_W-1:0]  scan_base;
  logic [ADDR_W-1:0]  sel;
  logic [ADDR_W-1:0]  idx;
  logic               found;
  logic               load;

  assign valid     = (state == PRESENT);
  assign busy      = (|pending) | valid;
  assign new_req   = enable ? req : '0;
  assign load      = (|pending) && (!valid || ack);
  assign scan_base = ROUND_ROBIN ? ptr : '0;

  // Scan pending upward from scan_base, wrapping, and take the first set slot.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    sel   = scan_base;
    idx   = scan_base;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = scan_base + ADDR_W'(i);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign clear_mask = load ? (NUM_REQ'(1) << sel) : '0;

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      addr    <= '0;
      ptr     <= '0;
      overrun <= 1'b0;
    end else begin
      // A fresh request on the slot being cleared wins, so the bit stays set.
      pending <= (pending & ~clear_mask) | new_req;
      overrun <= |(new_req & pending & ~clear_mask);
      if (load) begin
        state <= PRESENT;
        addr  <= sel;
        ptr   <= ROUND_ROBIN ? sel + ADDR_W'(1) : '0;
      end else if (ack && state == PRESENT) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder: a round-robin instance and a fixed-priority instance
// share stimulus; expected values are hand-derived per step.
module tb_req_encoder;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] req;
  logic        ack;

  logic [3:0]  addr,    fp_addr;
  logic        valid,   fp_valid;
  logic        busy,    fp_busy;
  logic        overrun, fp_overrun;

  int n_checks;
  int n_errors;

  req_encoder #(.NUM_REQ(16), .ADDR_W(4), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .addr(addr),
    .valid(valid), .ack(ack), .busy(busy), .overrun(overrun)
  );

  req_encoder #(.NUM_REQ(16), .ADDR_W(4), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .addr(fp_addr),
    .valid(fp_valid), .ack(ack), .busy(fp_busy), .overrun(fp_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    ack    = 1'b0;
    enable = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; req = '0; ack = 1'b0; enable = 1'b1;
    #3;
    check("rst_valid", 32'(valid), 32'd0);
    do_reset();
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // 1: single request, one-edge latency, ack returns to idle
    req = 16'h0001; step(); req = '0;
    check("t1_pend_valid", 32'(valid), 32'd0);
    check("t1_pend_busy", 32'(busy), 32'd1);
    step();
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_addr", 32'(addr), 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    check("t1_ack_valid", 32'(valid), 32'd0);
    check("t1_ack_busy", 32'(busy), 32'd0);

    // 2: two requests drained back-to-back with ack held
    do_reset();
    req = 16'h8001; step(); req = '0; ack = 1'b1;
    step();
    check("t2_addr0", 32'(addr), 32'd0);
    check("t2_valid0", 32'(valid), 32'd1);
    step();
    check("t2_addr15", 32'(addr), 32'd15);
    check("t2_valid15", 32'(valid), 32'd1);
    step();
    check("t2_done", 32'(valid), 32'd0);
    ack = 1'b0;

    // 3: pointer wrap and round-robin vs fixed priority
    do_reset();
    req = 16'h8000; step(); req = '0; step();
    check("t3_g15", 32'(addr), 32'd15);
    ack = 1'b1; step(); ack = 1'b0;
    req = 16'h8001; step(); req = '0; step();
    check("t3_wrap_rr", 32'(addr), 32'd0);
    check("t3_wrap_fp", 32'(fp_addr), 32'd0);
    ack = 1'b1; step();
    check("t3_second", 32'(addr), 32'd15);
    step(); ack = 1'b0;
    check("t3_idle", 32'(valid), 32'd0);
    req = 16'h0003; step(); req = '0; step();
    check("t3_first_rr", 32'(addr), 32'd0);
    check("t3_first_fp", 32'(fp_addr), 32'd0);
    req = 16'h0001; step(); req = '0;
    check("t3_merge_no_ovr", 32'(overrun), 32'd0);
    check("t3_hold_addr", 32'(addr), 32'd0);
    ack = 1'b1; step();
    check("t3_rr_a", 32'(addr), 32'd1);
    check("t3_fp_a", 32'(fp_addr), 32'd0);
    step();
    check("t3_rr_b", 32'(addr), 32'd0);
    check("t3_fp_b", 32'(fp_addr), 32'd1);
    step(); ack = 1'b0;
    check("t3_rr_idle", 32'(busy), 32'd0);
    check("t3_fp_idle", 32'(fp_busy), 32'd0);

    // 4a: request on the presented slot re-queues without overrun
    do_reset();
    req = 16'h0010; step(); step(); req = '0;
    check("t4_addr", 32'(addr), 32'd4);
    check("t4_requeue_ovr", 32'(overrun), 32'd0);
    step();
    check("t4_stable", 32'(addr), 32'd4);
    check("t4_stable_v", 32'(valid), 32'd1);
    ack = 1'b1; step();
    check("t4_regrant", 32'(addr), 32'd4);
    check("t4_regrant_v", 32'(valid), 32'd1);
    step(); ack = 1'b0;
    check("t4_empty", 32'(busy), 32'd0);

    // 4b: held request on an already-pending slot pulses overrun
    do_reset();
    req = 16'h0030; step();
    check("t4b_ovr0", 32'(overrun), 32'd0);
    step();
    check("t4b_addr", 32'(addr), 32'd4);
    check("t4b_ovr1", 32'(overrun), 32'd1);
    step();
    check("t4b_ovr2", 32'(overrun), 32'd1);
    req = '0; step();
    check("t4b_ovr_clear", 32'(overrun), 32'd0);
    ack = 1'b1; step();
    check("t4b_drain5", 32'(addr), 32'd5);
    step();
    check("t4b_drain4", 32'(addr), 32'd4);
    step(); ack = 1'b0;
    check("t4b_idle", 32'(busy), 32'd0);

    // 5: enable=0 ignores requests but pending still drains
    do_reset();
    enable = 1'b0; req = 16'hFFFF; step(); step();
    check("t5_ign_valid", 32'(valid), 32'd0);
    check("t5_ign_busy", 32'(busy), 32'd0);
    enable = 1'b1; req = 16'h0041; step();
    enable = 1'b0; req = 16'hFFFF; step();
    check("t5_g0", 32'(addr), 32'd0);
    ack = 1'b1; step();
    check("t5_g6", 32'(addr), 32'd6);
    step(); ack = 1'b0;
    check("t5_drained", 32'(busy), 32'd0);
    check("t5_no_ovr", 32'(overrun), 32'd0);
    req = '0; enable = 1'b1;

    // 6: asynchronous reset mid-operation
    do_reset();
    req = 16'h0380; step();
    req = 16'h0100; step(); req = '0;
    check("t6_addr", 32'(addr), 32'd7);
    check("t6_ovr", 32'(overrun), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_addr", 32'(addr), 32'd0);
    check("t6_rst_ovr", 32'(overrun), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step(); step(); step();
    check("t6_no_grant", 32'(valid), 32'd0);
    check("t6_no_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
